// File: rtl/board_if.sv
// Cursor/selection inputs and render/status outputs of the Minesweeper board engine.
interface board_if;
  logic [5:0] cursor_x;
  logic [5:0] cursor_y;
  logic       sel_start;
  logic       sel_sqr;
  logic       place_flag;
  logic [3:0] rd_x;
  logic [3:0] rd_y;
  logic [6:0] rd_cell;
  logic       busy;
  logic       game_won;
  logic       game_lost;
  logic [8:0] flags_left;
  logic [8:0] revealed_cnt;

  modport master (
    output cursor_x, cursor_y, sel_start, sel_sqr, place_flag, rd_x, rd_y,
    input  rd_cell, busy, game_won, game_lost, flags_left, revealed_cnt
  );

  modport slave (
    input  cursor_x, cursor_y, sel_start, sel_sqr, place_flag, rd_x, rd_y,
    output rd_cell, busy, game_won, game_lost, flags_left, revealed_cnt
  );
endinterface

// File: rtl/board_ctrl.sv
// Minesweeper game-state engine: owns the 16x16 board (mines, adjacency,
// revealed/flagged bits), places mines from a free-running LFSR, counts
// adjacency, runs reveal/flag/flood-fill and exposes a registered cell read port.
module board_ctrl #(
  parameter int          NUM_MINES = 40,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic    clk,
  input logic    rst,
  board_if.slave bus
);

  localparam logic [8:0] MINES_W = 9'(NUM_MINES);
  localparam logic [8:0] WIN_CNT = 9'(256 - NUM_MINES);

  typedef enum logic [2:0] {IDLE, CLEAR, PLACE, COUNT, PLAY, FLOOD, WON, LOST} state_t;

  state_t            state, state_nxt;
  logic [15:0]       lfsr;
  logic [255:0]      mine, revealed, flagged;
  logic [255:0][3:0] adj;
  logic [255:0][7:0] stack;
  logic [8:0]        sp, mine_cnt, flags_left, revealed_cnt, rcnt_nxt;
  logic [7:0]        cnt_idx, fcell, push_idx;
  logic [3:0]        fstep;
  logic [6:0]        rd_cell_p1;

  logic              play_rev, play_mine, flag_set, flag_clr, flood_rev, push, place_new;

  // Neighbour offsets in the order NW, N, NE, W, E, SW, S, SE (5-bit two's complement).
  function automatic logic [4:0] dx_of(input logic [2:0] k);
    logic [4:0] d;
    case (k)
      3'd0, 3'd3, 3'd5: d = 5'h1f;
      3'd1, 3'd6:       d = 5'h00;
      default:          d = 5'h01;
    endcase
    return d;
  endfunction

  function automatic logic [4:0] dy_of(input logic [2:0] k);
    logic [4:0] d;
    if (k <= 3'd2)      d = 5'h1f;
    else if (k <= 3'd4) d = 5'h00;
    else                d = 5'h01;
    return d;
  endfunction

  // Mines among the in-bounds neighbours of cell i; bit 4 of a coordinate flags off-board.
  function automatic logic [3:0] adj_of(input logic [255:0] m, input logic [7:0] i);
    logic [3:0] s;
    logic [4:0] ax, ay;
    s = 4'd0;
    for (int k = 0; k < 8; k++) begin
      ax = {1'b0, i[3:0]} + dx_of(3'(k));
      ay = {1'b0, i[7:4]} + dy_of(3'(k));
      if (!ax[4] && !ay[4]) s = s + {3'b000, m[{ay[3:0], ax[3:0]}]};
    end
    return s;
  endfunction

  logic       cur_on;
  logic [7:0] cur_idx, rd_idx, n_idx;
  logic [2:0] nk;
  logic [4:0] nx, ny;
  logic       n_on;

  assign cur_on  = (bus.cursor_x[5:4] == 2'b00) && (bus.cursor_y[5:4] == 2'b00);
  assign cur_idx = {bus.cursor_y[3:0], bus.cursor_x[3:0]};
  assign rd_idx  = {bus.rd_y, bus.rd_x};
  assign nk      = 3'(fstep - 4'd1);
  assign nx      = {1'b0, fcell[3:0]} + dx_of(nk);
  assign ny      = {1'b0, fcell[7:4]} + dy_of(nk);
  assign n_on    = (fstep != 4'd0) && !nx[4] && !ny[4];
  assign n_idx   = {ny[3:0], nx[3:0]};

  // Next-state and per-cycle action strobes.
  always_comb begin
    state_nxt = state;
    play_rev  = 1'b0;
    play_mine = 1'b0;
    flag_set  = 1'b0;
    flag_clr  = 1'b0;
    flood_rev = 1'b0;
    push      = 1'b0;
    push_idx  = cur_idx;
    place_new = 1'b0;
    rcnt_nxt  = revealed_cnt;
    case (state)
      IDLE, WON, LOST: if (bus.sel_start) state_nxt = CLEAR;
      CLEAR: state_nxt = PLACE;
      PLACE: begin
        if (mine_cnt == MINES_W) state_nxt = COUNT;
        else                     place_new = !mine[lfsr[7:0]];
      end
      COUNT: if (cnt_idx == 8'd255) state_nxt = PLAY;
      PLAY: begin
        if (cur_on && bus.sel_sqr) begin
          if (!revealed[cur_idx] && !flagged[cur_idx]) begin
            if (mine[cur_idx]) begin
              play_mine = 1'b1;
              state_nxt = LOST;
            end else begin
              play_rev = 1'b1;
              rcnt_nxt = revealed_cnt + 9'd1;
              if (adj[cur_idx] == 4'd0) begin
                push      = 1'b1;
                state_nxt = FLOOD;
              end else if (rcnt_nxt == WIN_CNT) begin
                state_nxt = WON;
              end
            end
          end
        end else if (cur_on && bus.place_flag && !revealed[cur_idx]) begin
          if (flagged[cur_idx])          flag_clr = 1'b1;
          else if (flags_left != 9'd0)   flag_set = 1'b1;
        end
      end
      FLOOD: begin
        if (n_on && !revealed[n_idx] && !flagged[n_idx] && !mine[n_idx]) begin
          flood_rev = 1'b1;
          rcnt_nxt  = revealed_cnt + 9'd1;
          push_idx  = n_idx;
          push      = (adj[n_idx] == 4'd0);
        end
        if (fstep == 4'd8 && sp == 9'd0 && !push)
          state_nxt = (rcnt_nxt == WIN_CNT) ? WON : PLAY;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Board storage, counters, LFSR, flood cursor and the registered read port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr         <= LFSR_SEED;
      mine         <= '0;
      revealed     <= '0;
      flagged      <= '0;
      adj          <= '0;
      mine_cnt     <= '0;
      cnt_idx      <= '0;
      sp           <= '0;
      fstep        <= '0;
      fcell        <= '0;
      flags_left   <= MINES_W;
      revealed_cnt <= '0;
      rd_cell_p1   <= '0;
    end else begin
      lfsr         <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      revealed_cnt <= rcnt_nxt;
      // read stage boundary: address sampled here, cell visible one cycle later
      rd_cell_p1   <= {revealed[rd_idx], flagged[rd_idx], mine[rd_idx] & (state == LOST),
                       revealed[rd_idx] ? adj[rd_idx] : 4'd0};
      case (state)
        CLEAR: begin
          mine         <= '0;
          revealed     <= '0;
          flagged      <= '0;
          adj          <= '0;
          revealed_cnt <= '0;
          flags_left   <= MINES_W;
          mine_cnt     <= '0;
          cnt_idx      <= '0;
          sp           <= '0;
          fstep        <= '0;
        end
        PLACE: begin
          if (place_new) begin
            mine[lfsr[7:0]] <= 1'b1;
            mine_cnt        <= mine_cnt + 9'd1;
          end
        end
        COUNT: begin
          adj[cnt_idx] <= adj_of(mine, cnt_idx);
          cnt_idx      <= cnt_idx + 8'd1;
        end
        PLAY: begin
          if (play_rev || play_mine) revealed[cur_idx] <= 1'b1;
          if (flag_set) begin
            flagged[cur_idx] <= 1'b1;
            flags_left       <= flags_left - 9'd1;
          end
          if (flag_clr) begin
            flagged[cur_idx] <= 1'b0;
            flags_left       <= flags_left + 9'd1;
          end
          if (push) sp <= sp + 9'd1;
          fstep <= '0;
        end
        FLOOD: begin
          if (fstep == 4'd0) begin
            fcell <= stack[8'(sp - 9'd1)];
            sp    <= sp - 9'd1;
            fstep <= 4'd1;
          end else begin
            if (flood_rev) revealed[n_idx] <= 1'b1;
            if (push)      sp <= sp + 9'd1;
            fstep <= (fstep == 4'd8) ? 4'd0 : fstep + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Flood stack contents; only the pointer is control state.
  always_ff @(posedge clk) begin
    if (push) stack[sp[7:0]] <= push_idx;
  end

  assign bus.rd_cell      = rd_cell_p1;
  assign bus.busy         = state inside {CLEAR, PLACE, COUNT, FLOOD};
  assign bus.game_won     = (state == WON);
  assign bus.game_lost    = (state == LOST);
  assign bus.flags_left   = flags_left;
  assign bus.revealed_cnt = revealed_cnt;

endmodule

// File: tb/tb_board_ctrl.sv
// Bench for board_ctrl: three instances (0, 1 and 40 mines) driven by directed
// and random cursor actions, compared against a cell-set model of the game.
module tb_board_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_n;
  logic [5:0] cx, cy;
  logic       st, sq, pf;
  logic [3:0] rx, ry;
  int         which;
  int         vectors = 0;
  int         miscompares = 0;
  int         last_wait;

  board_if b0();
  board_if b1();
  board_if b2();

  assign b0.cursor_x = cx; assign b0.cursor_y = cy; assign b0.rd_x = rx; assign b0.rd_y = ry;
  assign b0.sel_start = st & (which == 0); assign b0.sel_sqr = sq & (which == 0);
  assign b0.place_flag = pf & (which == 0);
  assign b1.cursor_x = cx; assign b1.cursor_y = cy; assign b1.rd_x = rx; assign b1.rd_y = ry;
  assign b1.sel_start = st & (which == 1); assign b1.sel_sqr = sq & (which == 1);
  assign b1.place_flag = pf & (which == 1);
  assign b2.cursor_x = cx; assign b2.cursor_y = cy; assign b2.rd_x = rx; assign b2.rd_y = ry;
  assign b2.sel_start = st & (which == 2); assign b2.sel_sqr = sq & (which == 2);
  assign b2.place_flag = pf & (which == 2);

  board_ctrl #(.NUM_MINES(0))  u0 (.clk(clk), .rst(rst_n[0]), .bus(b0.slave));
  board_ctrl #(.NUM_MINES(1))  u1 (.clk(clk), .rst(rst_n[1]), .bus(b1.slave));
  board_ctrl #(.NUM_MINES(40)) u2 (.clk(clk), .rst(rst_n[2]), .bus(b2.slave));

  logic [6:0]        o_rd;
  logic              o_busy, o_won, o_lost;
  logic [8:0]        o_fl, o_rc;
  logic [255:0]      bd_mine;
  logic [255:0][3:0] bd_adj;

  always_comb begin
    case (which)
      0: begin
        o_rd = b0.rd_cell; o_busy = b0.busy; o_won = b0.game_won; o_lost = b0.game_lost;
        o_fl = b0.flags_left; o_rc = b0.revealed_cnt; bd_mine = u0.mine; bd_adj = u0.adj;
      end
      1: begin
        o_rd = b1.rd_cell; o_busy = b1.busy; o_won = b1.game_won; o_lost = b1.game_lost;
        o_fl = b1.flags_left; o_rc = b1.revealed_cnt; bd_mine = u1.mine; bd_adj = u1.adj;
      end
      default: begin
        o_rd = b2.rd_cell; o_busy = b2.busy; o_won = b2.game_won; o_lost = b2.game_lost;
        o_fl = b2.flags_left; o_rc = b2.revealed_cnt; bd_mine = u2.mine; bd_adj = u2.adj;
      end
    endcase
  end

  // Reference model: game status per instance, board contents for the active one.
  localparam int S_IDLE = 0, S_PLAY = 1, S_WON = 2, S_LOST = 3;
  int ms[3] = '{S_IDLE, S_IDLE, S_IDLE};
  int nm_of[3] = '{0, 1, 40};
  bit m_mine[256];
  bit m_rev[256];
  bit m_flag[256];
  int m_adj[256];
  int m_fl, m_rc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit on_board(input int x, input int y);
    return (x >= 0) && (x < 16) && (y >= 0) && (y < 16);
  endfunction

  task automatic m_flood(input int c);
    int q[$];
    int p, nx, ny, n;
    q.push_back(c);
    while (q.size() > 0) begin
      p = q.pop_front();
      for (int dy = -1; dy <= 1; dy++)
        for (int dx = -1; dx <= 1; dx++) begin
          nx = p % 16 + dx;
          ny = p / 16 + dy;
          if ((dx != 0 || dy != 0) && on_board(nx, ny)) begin
            n = ny * 16 + nx;
            if (!m_rev[n] && !m_flag[n] && !m_mine[n]) begin
              m_rev[n] = 1'b1;
              m_rc++;
              if (m_adj[n] == 0) q.push_back(n);
            end
          end
        end
    end
  endtask

  task automatic m_step(input int op, input int x, input int y, output bit new_game);
    int c;
    new_game = 1'b0;
    if (ms[which] != S_PLAY) begin
      new_game = op[2];
      return;
    end
    if (x > 15 || y > 15) return;
    c = y * 16 + x;
    if (op[0]) begin
      if (!m_rev[c] && !m_flag[c]) begin
        m_rev[c] = 1'b1;
        if (m_mine[c]) ms[which] = S_LOST;
        else begin
          m_rc++;
          if (m_adj[c] == 0) m_flood(c);
          if (m_rc == 256 - nm_of[which]) ms[which] = S_WON;
        end
      end
    end else if (op[1] && !m_rev[c]) begin
      if (m_flag[c]) begin
        m_flag[c] = 1'b0;
        m_fl++;
      end else if (m_fl > 0) begin
        m_flag[c] = 1'b1;
        m_fl--;
      end
    end
  endtask

  task automatic m_load();
    int cnt;
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      m_mine[i] = bd_mine[i];
      m_rev[i]  = 1'b0;
      m_flag[i] = 1'b0;
      cnt += int'(bd_mine[i]);
    end
    chk("mine_count", cnt, nm_of[which]);
    for (int i = 0; i < 256; i++) begin
      m_adj[i] = 0;
      for (int dy = -1; dy <= 1; dy++)
        for (int dx = -1; dx <= 1; dx++)
          if ((dx != 0 || dy != 0) && on_board(i % 16 + dx, i / 16 + dy))
            m_adj[i] += int'(m_mine[(i / 16 + dy) * 16 + i % 16 + dx]);
      chk("adj_count", bd_adj[i], m_adj[i]);
    end
    m_fl = nm_of[which];
    m_rc = 0;
    ms[which] = S_PLAY;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_busy === 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    chk("busy_timeout", n < 5000, 1);
  endtask

  task automatic chk_status();
    chk("flags_left", o_fl, m_fl);
    chk("revealed_cnt", o_rc, m_rc);
    chk("game_won", o_won, ms[which] == S_WON);
    chk("game_lost", o_lost, ms[which] == S_LOST);
    chk("busy_idle", o_busy, 0);
  endtask

  task automatic act(input int op, input int x, input int y);
    bit ng;
    @(negedge clk);
    cx = 6'(x); cy = 6'(y);
    st = op[2]; sq = op[0]; pf = op[1];
    @(negedge clk);
    st = 1'b0; sq = 1'b0; pf = 1'b0;
    m_step(op, x, y, ng);
    if (ng) chk("busy_on_start", o_busy, 1);
    wait_idle();
    if (ng) m_load();
    chk_status();
  endtask

  task automatic scan(input string tag);
    logic [6:0] e;
    for (int i = 0; i < 256; i++) begin
      rx = 4'(i % 16);
      ry = 4'(i / 16);
      @(negedge clk);
      e = {m_rev[i], m_flag[i], m_mine[i] && (ms[which] == S_LOST),
           m_rev[i] ? 4'(m_adj[i]) : 4'd0};
      chk(tag, o_rd, e);
    end
  endtask

  task automatic rand_ops(input int n, input int scan_every);
    int r, x, y, op;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      x = $urandom_range(0, 15);
      y = $urandom_range(0, 15);
      if (ms[which] != S_PLAY && r < 50) op = 4;
      else if (r < 45) op = 1;
      else if (r < 75) op = 2;
      else if (r < 85) op = 3;
      else if (r < 92) op = 4;
      else begin
        op = 1;
        x  = 16 + $urandom_range(0, 40);
      end
      act(op, x, y);
      if (i % scan_every == 0) scan("rand_cell");
    end
  endtask

  int c_both, c_mine;

  initial begin
    rst_n = 3'b000;
    cx = '0; cy = '0; st = 1'b0; sq = 1'b0; pf = 1'b0; rx = '0; ry = '0;
    which = 0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      which = d;
      #1;
      chk("rst_rd_cell", o_rd, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_won", o_won, 0);
      chk("rst_lost", o_lost, 0);
      chk("rst_flags_left", o_fl, nm_of[d]);
      chk("rst_revealed_cnt", o_rc, 0);
    end
    @(negedge clk);
    rst_n = 3'b111;

    // zero mines: one reveal floods the whole board and wins
    which = 0;
    act(4, 0, 0);
    chk("nm0_busy_cycles", last_wait, 258);
    act(1, 5, 5);
    chk("nm0_revealed_all", o_rc, 256);
    chk("nm0_won", o_won, 1);
    scan("nm0_cell");

    // one mine: flag budget and flagged-cell protection
    which = 1;
    act(4, 0, 0);
    act(2, 0, 0);
    chk("flag_set", o_fl, 0);
    act(2, 1, 0);
    chk("flag_no_budget", o_fl, 0);
    act(2, 0, 0);
    chk("flag_clear", o_fl, 1);
    act(2, 0, 0);
    act(1, 0, 0);
    chk("flagged_reveal_blocked", o_rc, 0);
    act(2, 0, 0);
    scan("nm1_cell");
    rand_ops(25, 5);

    // forty mines: simultaneous pulses, off-board cursor, losing, restart
    which = 2;
    repeat ($urandom_range(1, 500)) @(negedge clk);
    act(4, 0, 0);
    c_both = -1;
    c_mine = -1;
    for (int i = 0; i < 256; i++) begin
      if (c_both < 0 && !m_mine[i] && m_adj[i] != 0) c_both = i;
      if (c_mine < 0 && m_mine[i]) c_mine = i;
    end
    act(3, c_both % 16, c_both / 16);
    rx = 4'(c_both % 16);
    ry = 4'(c_both / 16);
    @(negedge clk);
    chk("both_pulse_revealed", o_rd[6], 1);
    chk("both_pulse_no_flag", o_rd[5], 0);
    act(1, 20, 3);
    chk("offboard_no_change", o_rc, 1);
    act(1, c_mine % 16, c_mine / 16);
    chk("hit_mine_lost", o_lost, 1);
    scan("lost_cell");
    act(1, $urandom_range(0, 15), $urandom_range(0, 15));
    act(2, $urandom_range(0, 15), $urandom_range(0, 15));
    chk("lost_sticky", o_lost, 1);
    act(4, 0, 0);
    rand_ops(50, 1);

    // reset while flooding
    which = 0;
    act(4, 0, 0);
    @(negedge clk);
    cx = 6'd5; cy = 6'd5; sq = 1'b1;
    @(negedge clk);
    sq = 1'b0;
    repeat (30) @(negedge clk);
    chk("flood_busy", o_busy, 1);
    rx = 4'd5;
    ry = 4'd5;
    rst_n[0] = 1'b0;
    @(negedge clk);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_revealed_cnt", o_rc, 0);
    chk("midrst_rd_cell", o_rd, 0);
    chk("midrst_won", o_won, 0);
    chk("midrst_flags_left", o_fl, 0);
    chk("midrst_sp", u0.sp, 0);
    rst_n[0] = 1'b1;
    @(negedge clk);
    chk("midrst_cell_cleared", o_rd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
